div_seq_ctrl: RTL
=================

Name: div_seq_ctrl

Overview:
- Multi-cycle sequencer for the RV64M divide/remainder ops. The execute stage currently does these with single-cycle combinational dividers; this block replaces them.
- Accepts one request from the execute stage and asserts a stall so the E-stage registers hold.
- Runs a radix-2 restoring divide, handles the RISC-V special cases, and returns a 64-bit result with a one-cycle valid pulse.
- Multiply and all other ALU ops stay in the execute stage.

Parameters:
- XLEN, 64, datapath width; only 64 is supported.
- CNT_W, 7, iteration counter width; must hold XLEN.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous reset, active-high.
- div_i_valid  in  1  E-stage holds an instruction this cycle.
- div_i_op  in  8  one-hot, same bit order as alu_info[7:0]: [7] div, [6] divu, [5] divw, [4] divuw, [3] rem, [2] remu, [1] remw, [0] remuw.
- div_i_src1  in  64  dividend (rs1 data).
- div_i_src2  in  64  divisor (rs2 data).
- div_i_flush  in  1  kill the in-flight op (branch redirect or trap).
- div_o_ready  out  1  high only in IDLE.
- div_o_stall  out  1  hold the pipeline at E and upstream.
- div_o_valid  out  1  one-cycle pulse; div_o_result is valid in that cycle.
- div_o_result  out  64  quotient or remainder.

Behaviour:
- Reset: state=IDLE, counter=0, div_o_valid=0, div_o_result=0. Reset mid-operation aborts the op and produces no valid pulse.
- Accept condition: state==IDLE, div_i_valid=1, |div_i_op=1, div_i_flush=0. On that edge (call it T), latch the op, a W flag and the sign flags.
- Request with div_i_op==0: ignored; no stall.
- More than one op bit set: highest set bit wins.
- W ops (divw, divuw, remw, remuw):
  - Operands are the low 32 bits, sign-extended for signed ops and zero-extended for unsigned ops.
  - Iteration count is 32 instead of 64.
  - The final result is sign-extended from bit 31 for all four W ops, including divuw and remuw.
- Special cases, decided in IDLE at accept; state goes to DONE directly, so div_o_valid=1 in cycle T+1:
  - Divisor==0: quotient = all ones; remainder = dividend (for W, the sign-extended low 32 bits).
  - Signed overflow (dividend = most negative value for the width, divisor = -1): quotient = dividend (W: 0xFFFFFFFF80000000); remainder = 0.
- States and transitions (normal path):
  - IDLE -> PREP: on accept.
  - PREP: take absolute values for signed ops; load remainder=0, quotient=|dividend|, counter=N (64 or 32). -> CALC.
  - CALC: one shift-subtract step per cycle; counter decrements; -> FIX when counter reaches 0 after the last step.
  - FIX: negate the quotient if the operand signs differ; negate the remainder if the dividend is negative; register div_o_result. -> DONE.
  - DONE: div_o_valid=1 for exactly one cycle. -> IDLE.
- Latency: valid in cycle T+67 for 64-bit ops, T+35 for W ops, T+1 for special cases.
- Stall generation (combinational):
  - div_o_stall = (IDLE & div_i_valid & |div_i_op & ~div_i_flush) | (state ∉ {IDLE, DONE}).
  - Stall is low in DONE, so the pipeline advances and captures the result that cycle.
  - div_o_ready is low in DONE, so the same instruction cannot be re-accepted.
- Flush:
  - div_i_flush=1 in any state: next state IDLE, no valid pulse, stall drops in the same cycle.
  - Flush has priority over accept; rst has priority over flush.
- div_o_result holds its last value until the next FIX or special-case load; div_o_valid=0 in every other cycle.
- Source operands are sampled only at accept; later changes on the div_i_* inputs have no effect.

Test Plan:
- divu, src1=100, src2=7, accepted at T -> stall high T..T+66; valid=1 only in T+67; result=14; ready=1 at T+68.
- rem, src1=0xFFFFFFFFFFFFFFF9 (-7), src2=2 -> result=0xFFFFFFFFFFFFFFFF (-1) at T+67.
- divw, src1=0x12345678FFFFFFF9, src2=2 -> result=0xFFFFFFFFFFFFFFFD at T+35.
- divuw, src1=0xFFFFFFFF, src2=1 -> result=0xFFFFFFFFFFFFFFFF at T+35.
- Special cases, each with valid at T+1:
  - div, src2=0 -> result=0xFFFFFFFFFFFFFFFF.
  - remw, src1=0x0000000080000001, src2=0 -> result=0xFFFFFFFF80000001.
  - div, src1=0x8000000000000000, src2=-1 -> result=0x8000000000000000.
  - rem with the same operands -> result=0.
- Abort and reset mid-op:
  - div accepted at T, flush at T+10 -> stall low at T+10, no valid ever, ready=1 at T+11; a new divu accepted at T+11 completes at T+78.
  - rst at T+20 of a different op -> same abort behaviour.

Source files
------------

// File: rtl/div_seq_ctrl.sv
// div_seq_ctrl: multi-cycle sequencer for the RV64M divide/remainder ops.
// A request from the execute stage is accepted in IDLE; the pipeline is
// stalled while a radix-2 restoring divide runs (64 or 32 steps). The RISC-V
// special cases (divide by zero, signed overflow) finish without iterating.
// The result is presented with a one-cycle valid pulse in DONE.
module div_seq_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 7
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            div_i_valid,
    input  logic [7:0]      div_i_op,
    input  logic [XLEN-1:0] div_i_src1,
    input  logic [XLEN-1:0] div_i_src2,
    input  logic            div_i_flush,
    output logic            div_o_ready,
    output logic            div_o_stall,
    output logic            div_o_valid,
    output logic [XLEN-1:0] div_o_result
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_PREP = 3'd1,
        S_CALC = 3'd2,
        S_FIX  = 3'd3,
        S_DONE = 3'd4
    } state_t;

    // Sign-extend a 32-bit value to the full datapath width.
    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

    // Zero-extend a 32-bit value to the full datapath width.
    function automatic logic [63:0] zext32(input logic [31:0] v);
        return {32'h0000_0000, v};
    endfunction

    // Two's-complement negate when neg is set.
    function automatic logic [63:0] cond_neg(input logic [63:0] v, input logic neg);
        logic [63:0] r;
        if (neg) begin
            r = 64'd0 - v;
        end else begin
            r = v;
        end
        return r;
    endfunction

    // Final result formatting: every W op returns bit 31 sign-extended.
    function automatic logic [63:0] fmt_result(input logic [63:0] v, input logic is_w);
        logic [63:0] r;
        if (is_w) begin
            r = sext32(v[31:0]);
        end else begin
            r = v;
        end
        return r;
    endfunction

    state_t            state_r;
    state_t            state_nxt_s;
    logic [CNT_W-1:0]  cnt_r;
    logic              is_rem_r;
    logic              is_w_r;
    logic              neg_q_r;
    logic              neg_r_r;
    logic              dvd_neg_r;
    logic [XLEN-1:0]   opa_r;
    logic [XLEN-1:0]   opb_r;
    logic [XLEN-1:0]   rem_r;
    logic [XLEN-1:0]   quo_r;
    logic [XLEN-1:0]   dvs_r;
    logic [XLEN-1:0]   result_r;
    logic              valid_r;

    logic              dec_signed_s;
    logic              dec_rem_s;
    logic              dec_w_s;
    logic [XLEN-1:0]   opa_s;
    logic [XLEN-1:0]   opb_s;
    logic              dvd_neg_s;
    logic              dvs_neg_s;
    logic              div_zero_s;
    logic              ovf_s;
    logic              special_s;
    logic [XLEN-1:0]   spec_res_s;
    logic              accept_s;
    logic [XLEN:0]     shifted_s;
    logic [XLEN+1:0]   diff_s;
    logic [XLEN-1:0]   abs_a_s;
    logic [XLEN-1:0]   fix_res_s;

    // Priority decode of the one-hot op: the highest set bit wins.
    always_comb begin
        dec_signed_s = 1'b0;
        dec_rem_s    = 1'b0;
        dec_w_s      = 1'b0;
        if (div_i_op[7]) begin          // div
            dec_signed_s = 1'b1;
        end else if (div_i_op[6]) begin // divu
            dec_signed_s = 1'b0;
        end else if (div_i_op[5]) begin // divw
            dec_signed_s = 1'b1;
            dec_w_s      = 1'b1;
        end else if (div_i_op[4]) begin // divuw
            dec_w_s      = 1'b1;
        end else if (div_i_op[3]) begin // rem
            dec_signed_s = 1'b1;
            dec_rem_s    = 1'b1;
        end else if (div_i_op[2]) begin // remu
            dec_rem_s    = 1'b1;
        end else if (div_i_op[1]) begin // remw
            dec_signed_s = 1'b1;
            dec_rem_s    = 1'b1;
            dec_w_s      = 1'b1;
        end else begin                  // remuw (or no op, which is never accepted)
            dec_rem_s    = 1'b1;
            dec_w_s      = 1'b1;
        end
    end

    // Operand extension, sign flags and special-case detection at accept.
    always_comb begin
        opa_s = div_i_src1;
        opb_s = div_i_src2;
        if (dec_w_s) begin
            if (dec_signed_s) begin
                opa_s = sext32(div_i_src1[31:0]);
                opb_s = sext32(div_i_src2[31:0]);
            end else begin
                opa_s = zext32(div_i_src1[31:0]);
                opb_s = zext32(div_i_src2[31:0]);
            end
        end else begin
            opa_s = div_i_src1;
            opb_s = div_i_src2;
        end
        dvd_neg_s  = dec_signed_s & opa_s[63];
        dvs_neg_s  = dec_signed_s & opb_s[63];
        div_zero_s = (opb_s == 64'd0);
        // Most negative value is width dependent; W operands are already sign-extended.
        ovf_s = dec_signed_s & (opb_s == 64'hFFFF_FFFF_FFFF_FFFF) &
                (opa_s == (dec_w_s ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
        special_s = div_zero_s | ovf_s;
        if (div_zero_s) begin
            spec_res_s = fmt_result(dec_rem_s ? opa_s : 64'hFFFF_FFFF_FFFF_FFFF, dec_w_s);
        end else begin
            spec_res_s = fmt_result(dec_rem_s ? 64'd0 : opa_s, dec_w_s);
        end
        accept_s = (state_r == S_IDLE) & div_i_valid & (|div_i_op) & ~div_i_flush;
    end

    // One restoring step and the final sign fix-up.
    always_comb begin
        shifted_s = {rem_r, quo_r[63]};
        diff_s    = {1'b0, shifted_s} - {2'b00, dvs_r};
        abs_a_s   = cond_neg(opa_r, dvd_neg_r);
        fix_res_s = fmt_result(is_rem_r ? cond_neg(rem_r, neg_r_r) : cond_neg(quo_r, neg_q_r),
                               is_w_r);
    end

    // Next-state logic; flush returns to IDLE from anywhere.
    always_comb begin
        state_nxt_s = state_r;
        if (div_i_flush) begin
            state_nxt_s = S_IDLE;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        state_nxt_s = special_s ? S_DONE : S_PREP;
                    end else begin
                        state_nxt_s = S_IDLE;
                    end
                end
                S_PREP: state_nxt_s = S_CALC;
                S_CALC: begin
                    if (cnt_r == CNT_W'(1)) begin
                        state_nxt_s = S_FIX;
                    end else begin
                        state_nxt_s = S_CALC;
                    end
                end
                S_FIX:   state_nxt_s = S_DONE;
                S_DONE:  state_nxt_s = S_IDLE;
                default: state_nxt_s = S_IDLE;
            endcase
        end
    end

    // Handshake outputs: stall drops in DONE and whenever a flush is present.
    always_comb begin
        div_o_ready = (state_r == S_IDLE);
        div_o_stall = accept_s |
                      (~div_i_flush & (state_r != S_IDLE) & (state_r != S_DONE));
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= S_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // Valid pulse is registered: high exactly in the DONE cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_r <= 1'b0;
        end else begin
            valid_r <= (state_nxt_s == S_DONE);
        end
    end

    // Datapath: operand capture, iteration registers and result register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_r     <= '0;
            is_rem_r  <= 1'b0;
            is_w_r    <= 1'b0;
            neg_q_r   <= 1'b0;
            neg_r_r   <= 1'b0;
            dvd_neg_r <= 1'b0;
            opa_r     <= 64'd0;
            opb_r     <= 64'd0;
            rem_r     <= 64'd0;
            quo_r     <= 64'd0;
            dvs_r     <= 64'd0;
            result_r  <= 64'd0;
        end else begin
            case (state_r)
                S_IDLE: begin
                    if (accept_s) begin
                        is_rem_r  <= dec_rem_s;
                        is_w_r    <= dec_w_s;
                        dvd_neg_r <= dvd_neg_s;
                        neg_q_r   <= dvd_neg_s ^ dvs_neg_s;
                        neg_r_r   <= dvd_neg_s;
                        opa_r     <= opa_s;
                        opb_r     <= opb_s;
                        if (special_s) begin
                            result_r <= spec_res_s;
                        end
                    end
                end
                S_PREP: begin
                    rem_r <= 64'd0;
                    dvs_r <= cond_neg(opb_r, neg_q_r ^ neg_r_r);
                    // W ops iterate 32 times, so the dividend starts in the upper half.
                    if (is_w_r) begin
                        quo_r <= {abs_a_s[31:0], 32'h0000_0000};
                        cnt_r <= CNT_W'(32);
                    end else begin
                        quo_r <= abs_a_s;
                        cnt_r <= CNT_W'(XLEN);
                    end
                end
                S_CALC: begin
                    cnt_r <= cnt_r - CNT_W'(1);
                    if (diff_s[XLEN+1]) begin
                        rem_r <= shifted_s[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b0};
                    end else begin
                        rem_r <= diff_s[XLEN-1:0];
                        quo_r <= {quo_r[XLEN-2:0], 1'b1};
                    end
                end
                S_FIX: begin
                    if (!div_i_flush) begin
                        result_r <= fix_res_s;
                    end
                end
                default: begin
                    cnt_r <= cnt_r;
                end
            endcase
        end
    end

    assign div_o_valid  = valid_r;
    assign div_o_result = result_r;

endmodule
